// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants for the elevator operator-input front end
package elevator_pkg;

  localparam int NUM_FLOORS = 3;
  localparam int NUM_CH     = 6;

  localparam int CH_BTN1    = 0;
  localparam int CH_BTN2    = 1;
  localparam int CH_BTN3    = 2;
  localparam int CH_SOS     = 3;
  localparam int CH_WEIGHT  = 4;
  localparam int CH_WRESET  = 5;

  localparam logic BTN_IDLE = 1'b1;
  localparam logic SW_IDLE  = 1'b0;

  // Long enough for a level already present at reset release to pass sync, debounce and edge detect.
  function automatic int settle_cycles(input int debounce);
    return 2 * debounce + 4;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - 2-FF synchroniser, run-length debouncer and registered edge pulses
module debounce_channel #(
  parameter int   DEBOUNCE_CYCLES = 10,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= IDLE_LEVEL;
      sync2    <= IDLE_LEVEL;
      stable   <= IDLE_LEVEL;
      stable_d <= IDLE_LEVEL;
      cnt      <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      // cnt holds the number of earlier consecutive samples that disagreed with stable
      if (sync2 != stable) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt    <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      stable_d <= stable;
      rise     <= stable & ~stable_d;
      fall     <= ~stable & stable_d;
    end
  end

  assign level = stable_d;

endmodule

// File: rtl/elevator_input_conditioner.sv
// rtl/elevator_input_conditioner.sv - debounced floor calls, SOS level and switch-toggle events
// Optional build macro STUCK_DETECT_EN adds per-button stuck detection and masking.
module elevator_input_conditioner
  import elevator_pkg::*;
#(
  parameter int CLK_FREQ        = 500,
  parameter int DEBOUNCE_CYCLES = CLK_FREQ / 50,
  parameter int STUCK_CYCLES    = CLK_FREQ * 10
) (
  input  logic                  clk_50,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] button_n,
  input  logic                  sos_flip,
  input  logic                  weight_flip,
  input  logic                  weight_flip_reset,
  input  logic [NUM_FLOORS-1:0] floor_served,
  output logic [NUM_FLOORS-1:0] call_pending,
  output logic [NUM_FLOORS-1:0] call_pulse,
  output logic                  sos_level,
  output logic                  sos_changed,
  output logic                  person_in,
  output logic                  people_clear,
  output logic [NUM_FLOORS-1:0] stuck
);

  localparam int SETTLE = settle_cycles(DEBOUNCE_CYCLES);
  localparam int SW     = $clog2(SETTLE + 1);

  logic [NUM_CH-1:0]     raw;
  logic [NUM_CH-1:0]     level;
  logic [NUM_CH-1:0]     rise;
  logic [NUM_CH-1:0]     fall;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] stuck_q;
  logic [SW-1:0]         settle_cnt;
  logic                  settled;
  logic                  spare_unused;

  assign raw[CH_BTN3:CH_BTN1] = button_n;
  assign raw[CH_SOS]          = sos_flip;
  assign raw[CH_WEIGHT]       = weight_flip;
  assign raw[CH_WRESET]       = weight_flip_reset;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      ((g < NUM_FLOORS) ? BTN_IDLE : SW_IDLE)
    ) u_ch (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .raw     (raw[g]),
      .level   (level[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

  // Switch events are swallowed until the power-on level has worked through the debouncers.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  assign settled = (settle_cnt == SW'(SETTLE));

  assign press = fall[CH_BTN3:CH_BTN1] & ~stuck_q & {NUM_FLOORS{~sos_level}};

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      call_pending <= '0;
      call_pulse   <= '0;
      sos_level    <= 1'b0;
      sos_changed  <= 1'b0;
      person_in    <= 1'b0;
      people_clear <= 1'b0;
    end else begin
      call_pulse   <= press;
      call_pending <= (call_pending & ~floor_served) | press;
      sos_level    <= level[CH_SOS];
      sos_changed  <= settled & (rise[CH_SOS] | fall[CH_SOS]);
      person_in    <= settled & (rise[CH_WEIGHT] | fall[CH_WEIGHT]);
      people_clear <= settled & (rise[CH_WRESET] | fall[CH_WRESET]);
    end
  end

`ifdef STUCK_DETECT_EN
  localparam int HW = $clog2(STUCK_CYCLES + 1);

  logic [HW-1:0] hold_cnt [NUM_FLOORS];

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      stuck_q <= '0;
      for (int i = 0; i < NUM_FLOORS; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (level[i]) begin
          hold_cnt[i] <= '0;
          stuck_q[i]  <= 1'b0;
        end else if (!stuck_q[i]) begin
          if (hold_cnt[i] == HW'(STUCK_CYCLES - 1)) stuck_q[i] <= 1'b1;
          else hold_cnt[i] <= hold_cnt[i] + HW'(1);
        end
      end
    end
  end

  assign spare_unused = ^{rise[CH_BTN3:CH_BTN1], level[CH_WEIGHT], level[CH_WRESET]};
`else
  assign stuck_q      = '0;
  assign spare_unused = ^{rise[CH_BTN3:CH_BTN1], level[CH_BTN3:CH_BTN1],
                          level[CH_WEIGHT], level[CH_WRESET], (STUCK_CYCLES > 0)};
`endif

  assign stuck = stuck_q;

endmodule

// File: tb/tb_elevator_input_conditioner.sv
// tb/tb_elevator_input_conditioner.sv - self-checking bench for elevator_input_conditioner
module tb_elevator_input_conditioner;

  localparam int D      = 10;
  localparam int SETTLE = 2 * D + 4;
  localparam logic [5:0] IDLE = 6'b000111;

  logic       clk_50;
  logic       reset_n;
  logic [2:0] button_n;
  logic       sos_flip;
  logic       weight_flip;
  logic       weight_flip_reset;
  logic [2:0] floor_served;
  logic [2:0] call_pending;
  logic [2:0] call_pulse;
  logic       sos_level;
  logic       sos_changed;
  logic       person_in;
  logic       people_clear;
  logic [2:0] stuck;

  elevator_input_conditioner #(
    .CLK_FREQ        (500),
    .DEBOUNCE_CYCLES (D),
    .STUCK_CYCLES    (50)
  ) dut (
    .clk_50            (clk_50),
    .reset_n           (reset_n),
    .button_n          (button_n),
    .sos_flip          (sos_flip),
    .weight_flip       (weight_flip),
    .weight_flip_reset (weight_flip_reset),
    .floor_served      (floor_served),
    .call_pending      (call_pending),
    .call_pulse        (call_pulse),
    .sos_level         (sos_level),
    .sos_changed       (sos_changed),
    .person_in         (person_in),
    .people_clear      (people_clear),
    .stuck             (stuck)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  int n_vec = 0;
  int n_bad = 0;
  int cnt_calls = 0, cnt_sos = 0, cnt_person = 0, cnt_clear = 0;

  // Reference model: each pin's run of identical samples; a run of D samples that differs from
  // the accepted level becomes the new level, and its event is visible 4 edges later.
  int         m_n;
  logic [5:0] run_val, lvl, due_val;
  int         run_len [6];
  int         due [6];
  logic [2:0] m_pend, m_cpulse;
  logic       m_sos, m_sosch, m_pin, m_pclr;

  task automatic model_reset();
    m_n = 0;
    run_val = IDLE;
    lvl = IDLE;
    due_val = IDLE;
    for (int c = 0; c < 6; c++) begin
      run_len[c] = 0;
      due[c] = -1;
    end
    m_pend = '0; m_cpulse = '0;
    m_sos = 0; m_sosch = 0; m_pin = 0; m_pclr = 0;
  endtask

  task automatic model_step();
    logic [5:0] pin;
    logic [2:0] acc;
    logic       ok;
    m_n++;
    ok = (m_n - 1 >= SETTLE);
    pin = {weight_flip_reset, weight_flip, sos_flip, button_n};
    acc = '0; m_sosch = 0; m_pin = 0; m_pclr = 0;
    for (int c = 0; c < 6; c++) begin
      if (due[c] == m_n) begin
        if (c < 3) begin
          if (!due_val[c] && !m_sos) acc[c] = 1'b1;
        end else if (c == 3) begin
          m_sosch = ok;
          m_sos = due_val[3];
        end else if (c == 4) begin
          m_pin = ok;
        end else begin
          m_pclr = ok;
        end
      end
    end
    m_cpulse = acc;
    m_pend = (m_pend & ~floor_served) | acc;
    for (int c = 0; c < 6; c++) begin
      if (pin[c] == run_val[c]) run_len[c]++;
      else begin
        run_val[c] = pin[c];
        run_len[c] = 1;
      end
      if (run_len[c] == D && run_val[c] != lvl[c]) begin
        lvl[c] = run_val[c];
        due_val[c] = run_val[c];
        due[c] = m_n + 4;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk_50) begin
    logic [14:0] got, want;
    logic [2:0]  got_stuck;
`ifdef STUCK_DETECT_EN
    got_stuck = 3'b000;
`else
    got_stuck = stuck;
`endif
    got  = {call_pending, call_pulse, sos_level, sos_changed, person_in, people_clear, got_stuck};
    want = {m_pend, m_cpulse, m_sos, m_sosch, m_pin, m_pclr, 3'b000};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL model_cycle t=%0t got=%b want=%b", $time, got, want);
    end
    cnt_calls  += $countones(call_pulse);
    cnt_sos    += int'(sos_changed);
    cnt_person += int'(person_in);
    cnt_clear  += int'(people_clear);
  end

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  typedef struct {
    logic [2:0] btn_n;
    logic       sos, wf, wfr;
    logic [2:0] fs;
    int         len;
    logic [2:0] exp_pend;
    logic       exp_sos;
    int         exp_calls, exp_person, exp_clear;
  } seg_t;

  seg_t segs [15];

  initial begin
    int c0, p0, s0, k0, len;

    segs[0]  = '{3'b011, 1'b0, 1'b1, 1'b0, 3'b000, 125, 3'b100, 1'b0, 1, 0, 0};
    segs[1]  = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b000,  60, 3'b100, 1'b0, 0, 0, 0};
    segs[2]  = '{3'b110, 1'b0, 1'b1, 1'b0, 3'b000,   9, 3'b100, 1'b0, 0, 0, 0};
    segs[3]  = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b000,  40, 3'b100, 1'b0, 0, 0, 0};
    segs[4]  = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 250, 3'b100, 1'b0, 0, 1, 0};
    segs[5]  = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b000, 250, 3'b100, 1'b0, 0, 1, 0};
    segs[6]  = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b000,  60, 3'b100, 1'b0, 0, 0, 1};
    segs[7]  = '{3'b111, 1'b1, 1'b1, 1'b1, 3'b000,  60, 3'b100, 1'b1, 0, 0, 0};
    segs[8]  = '{3'b011, 1'b1, 1'b1, 1'b1, 3'b000,  60, 3'b100, 1'b1, 0, 0, 0};
    segs[9]  = '{3'b111, 1'b1, 1'b1, 1'b1, 3'b000,  60, 3'b100, 1'b1, 0, 0, 0};
    segs[10] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b000,  60, 3'b100, 1'b0, 0, 0, 0};
    segs[11] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b100,  30, 3'b000, 1'b0, 0, 0, 0};
    segs[12] = '{3'b101, 1'b0, 1'b1, 1'b1, 3'b000,  60, 3'b010, 1'b0, 1, 0, 0};
    segs[13] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b010,  40, 3'b000, 1'b0, 0, 0, 0};
    segs[14] = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000,  60, 3'b000, 1'b0, 0, 1, 1};

    reset_n = 0; button_n = 3'b111; sos_flip = 0; weight_flip = 1;
    weight_flip_reset = 0; floor_served = '0;
    cycles(5);
    check("reset_outputs", int'({call_pending, call_pulse, sos_level, sos_changed,
                                 person_in, people_clear, stuck}), 0);
    reset_n = 1;
    cycles(60);
    check("poweron_switch_silent", cnt_person, 0);
    check("poweron_sos_level", int'(sos_level), 0);

`ifdef STUCK_DETECT_EN
    button_n[0] = 0;
    cycles(100);
    check("stuck_set", int'(stuck[0]), 1);
    button_n[0] = 1;
    cycles(30);
    check("stuck_clear", int'(stuck), 0);
    floor_served = 3'b001;
    cycles(1);
    floor_served = '0;
    cycles(5);
`endif

    for (int i = 0; i < 15; i++) begin
      c0 = cnt_calls; p0 = cnt_person; s0 = cnt_clear;
      button_n = segs[i].btn_n; sos_flip = segs[i].sos;
      weight_flip = segs[i].wf; weight_flip_reset = segs[i].wfr;
      if (segs[i].fs != 3'b000) begin
        floor_served = segs[i].fs;
        cycles(1);
        floor_served = '0;
        cycles(segs[i].len - 1);
      end else begin
        cycles(segs[i].len);
      end
      check($sformatf("seg%0d_pending", i), int'(call_pending), int'(segs[i].exp_pend));
      check($sformatf("seg%0d_sos_level", i), int'(sos_level), int'(segs[i].exp_sos));
      check($sformatf("seg%0d_calls", i), cnt_calls - c0, segs[i].exp_calls);
      check($sformatf("seg%0d_person", i), cnt_person - p0, segs[i].exp_person);
      check($sformatf("seg%0d_clear", i), cnt_clear - s0, segs[i].exp_clear);
    end

    c0 = cnt_calls;
    repeat (4) begin
      button_n[0] = 0; cycles(3);
      button_n[0] = 1; cycles(3);
    end
    button_n[0] = 0; cycles(20);
    button_n[0] = 1; cycles(40);
    check("chatter_pulses", cnt_calls - c0, 1);
    check("chatter_pending", int'(call_pending), 1);
    floor_served = 3'b001; cycles(1); floor_served = '0;
    cycles(10);
    check("chatter_served", int'(call_pending), 0);

    button_n[1] = 0;
    cycles(13);
    check("race_early", int'(call_pulse[1]), 0);
    floor_served = 3'b010;
    cycles(1);
    floor_served = '0;
    check("race_latency", int'(call_pulse[1]), 1);
    check("race_set_wins", int'(call_pending[1]), 1);
    cycles(4);
    floor_served = 3'b010;
    cycles(1);
    floor_served = '0;
    check("race_clear", int'(call_pending[1]), 0);
    button_n[1] = 1;
    cycles(30);

    p0 = cnt_person;
    for (int t = 0; t < 7; t++) begin
      weight_flip = ~weight_flip;
      cycles(250);
    end
    check("toggle_count", cnt_person - p0, 7);

    button_n[2] = 0;
    cycles(6);
    reset_n = 0;
    #1;
    check("reset_abort_outputs", int'({call_pending, call_pulse, sos_level, sos_changed,
                                       person_in, people_clear, stuck}), 0);
    button_n = 3'b111;
    cycles(3);
    c0 = cnt_calls; p0 = cnt_person; k0 = cnt_sos;
    reset_n = 1;
    cycles(60);
    check("reset_no_pulse", cnt_calls - c0, 0);
    check("reset_pending", int'(call_pending), 0);
    check("reset_adopt_switch", cnt_person - p0, 0);
    check("reset_no_sos", cnt_sos - k0, 0);

    for (int r = 0; r < 700; r++) begin
      len = $urandom_range(1, 30);
      case ($urandom_range(0, 5))
        0, 1:    button_n = 3'($urandom);
        2:       button_n = 3'b111;
        3:       sos_flip = ~sos_flip;
        4:       weight_flip = ~weight_flip;
        default: weight_flip_reset = ~weight_flip_reset;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        floor_served = 3'($urandom);
        cycles(1);
        floor_served = '0;
      end
      cycles(len);
    end
    cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
